// File: rtl/axi_resp_pkg.sv
// Shared AXI encodings and FSM state types for the memory responder.
package axi_resp_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // WRAP walks linearly like INCR; the reserved encoding holds the index like FIXED.
  function automatic logic burst_advances(input logic [1:0] burst);
    return (burst == BURST_INCR) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Simple dual-port RAM: byte-enabled write port, read port registered once (data 1 cycle after i_re).
// o_rdata only changes on i_re, so the caller can park it while the consumer stalls.
module axi_mem_responder_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_re,
  input  logic [AW-1:0]       i_raddr,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Read sees the pre-write word when both ports hit the same index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI slave over on-chip RAM; one burst per direction, first R beat 2 cycles after AR, B the cycle after WLAST.
// B/R hold until accepted. Build with AXI_RESP_DECERR_EN to answer out-of-range addresses with DECERR.
module axi_mem_responder
  import axi_resp_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 8
) (
  input  logic                s_axi_clk,
  input  logic                s_aresetn,
  input  logic [ID_W-1:0]     s_axi_AWID,
  input  logic [31:0]         s_axi_AWADDR,
  input  logic [7:0]          s_axi_AWLEN,
  input  logic [1:0]          s_axi_AWBURST,
  input  logic                s_axi_AWVALID,
  output logic                s_axi_AWREADY,
  input  logic [DATA_W-1:0]   s_axi_WDATA,
  input  logic [DATA_W/8-1:0] s_axi_WSTRB,
  input  logic                s_axi_WLAST,
  input  logic                s_axi_WVALID,
  output logic                s_axi_WREADY,
  output logic [ID_W-1:0]     s_axi_BID,
  output logic [1:0]          s_axi_BRESP,
  output logic                s_axi_BVALID,
  input  logic                s_axi_BREADY,
  input  logic [ID_W-1:0]     s_axi_ARID,
  input  logic [31:0]         s_axi_ARADDR,
  input  logic [7:0]          s_axi_ARLEN,
  input  logic [1:0]          s_axi_ARBURST,
  input  logic                s_axi_ARVALID,
  output logic                s_axi_ARREADY,
  output logic [ID_W-1:0]     s_axi_RID,
  output logic [DATA_W-1:0]   s_axi_RDATA,
  output logic [1:0]          s_axi_RRESP,
  output logic                s_axi_RLAST,
  output logic                s_axi_RVALID,
  input  logic                s_axi_RREADY
);

  wstate_e r_wstate, w_wstate_nxt;
  rstate_e r_rstate, w_rstate_nxt;
  logic              r_rst_done;
  logic [ID_W-1:0]   r_awid, r_arid;
  logic [MEM_AW-1:0] r_widx, r_ridx;
  logic [7:0]        r_awlen;
  logic [8:0]        r_wcnt, r_rleft;
  logic              r_w_adv, r_r_adv, r_w_decerr, r_r_decerr;
  logic [1:0]        r_bresp;
  logic              r_rvalid, r_rlast;
  logic              w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_mem_we, w_mem_re;
  logic              w_aw_oor, w_ar_oor, w_unused_addr;
  logic [DATA_W-1:0] w_mem_q;

`ifdef AXI_RESP_DECERR_EN
  assign w_aw_oor      = |s_axi_AWADDR[31:MEM_AW+2];
  assign w_ar_oor      = |s_axi_ARADDR[31:MEM_AW+2];
  assign w_unused_addr = ^{s_axi_AWADDR[1:0], s_axi_ARADDR[1:0]};
`else
  assign w_aw_oor      = 1'b0;
  assign w_ar_oor      = 1'b0;
  assign w_unused_addr = ^{s_axi_AWADDR[31:MEM_AW+2], s_axi_AWADDR[1:0],
                           s_axi_ARADDR[31:MEM_AW+2], s_axi_ARADDR[1:0]};
`endif

  assign w_aw_hs  = s_axi_AWVALID & s_axi_AWREADY;
  assign w_w_hs   = s_axi_WVALID & s_axi_WREADY;
  assign w_ar_hs  = s_axi_ARVALID & s_axi_ARREADY;
  assign w_r_hs   = r_rvalid & s_axi_RREADY;
  assign w_mem_we = w_w_hs && (r_wcnt <= {1'b0, r_awlen}) && !r_w_decerr;
  // Fetch the next beat only when the output slot is empty or being drained this cycle.
  assign w_mem_re = (r_rstate == R_DATA) && (r_rleft != '0) && (!r_rvalid || s_axi_RREADY);

  always_ff @(posedge s_axi_clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_rst_done <= 1'b0;
      r_wstate   <= W_IDLE;
      r_rstate   <= R_IDLE;
    end else begin
      r_rst_done <= 1'b1;
      r_wstate   <= w_wstate_nxt;
      r_rstate   <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt  = r_wstate;
    s_axi_AWREADY = 1'b0;
    s_axi_WREADY  = 1'b0;
    s_axi_BVALID  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        s_axi_AWREADY = r_rst_done;
        if (s_axi_AWVALID && r_rst_done) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi_WREADY = 1'b1;
        if (s_axi_WVALID && s_axi_WLAST) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi_BVALID = 1'b1;
        if (s_axi_BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt  = r_rstate;
    s_axi_ARREADY = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        s_axi_ARREADY = r_rst_done;
        if (s_axi_ARVALID && r_rst_done) w_rstate_nxt = R_DATA;
      end
      R_DATA: if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_awid     <= '0;
      r_widx     <= '0;
      r_awlen    <= '0;
      r_wcnt     <= '0;
      r_w_adv    <= 1'b0;
      r_w_decerr <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_awid     <= s_axi_AWID;
        r_widx     <= s_axi_AWADDR[MEM_AW+1:2];
        r_awlen    <= s_axi_AWLEN;
        r_wcnt     <= '0;
        r_w_adv    <= burst_advances(s_axi_AWBURST);
        r_w_decerr <= w_aw_oor;
      end
      if (w_w_hs) begin
        if (r_wcnt != '1) r_wcnt <= r_wcnt + 9'd1;
        if (w_mem_we && r_w_adv) r_widx <= r_widx + MEM_AW'(1);
        // r_wcnt still excludes the WLAST beat here, hence the compare against LEN.
        if (s_axi_WLAST) begin
          r_bresp <= r_w_decerr ? RESP_DECERR :
                     (r_wcnt == {1'b0, r_awlen}) ? RESP_OKAY : RESP_SLVERR;
        end
      end
    end
  end

  always_ff @(posedge s_axi_clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_arid     <= '0;
      r_ridx     <= '0;
      r_rleft    <= '0;
      r_r_adv    <= 1'b0;
      r_r_decerr <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_arid     <= s_axi_ARID;
        r_ridx     <= s_axi_ARADDR[MEM_AW+1:2];
        r_rleft    <= {1'b0, s_axi_ARLEN} + 9'd1;
        r_r_adv    <= burst_advances(s_axi_ARBURST);
        r_r_decerr <= w_ar_oor;
      end
      if (w_mem_re) begin
        r_rleft  <= r_rleft - 9'd1;
        if (r_r_adv) r_ridx <= r_ridx + MEM_AW'(1);
        r_rvalid <= 1'b1;
        r_rlast  <= (r_rleft == 9'd1);
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  assign s_axi_BID    = r_awid;
  assign s_axi_BRESP  = r_bresp;
  assign s_axi_RID    = r_arid;
  assign s_axi_RVALID = r_rvalid;
  assign s_axi_RLAST  = r_rlast;
  assign s_axi_RRESP  = r_r_decerr ? RESP_DECERR : RESP_OKAY;
  assign s_axi_RDATA  = r_r_decerr ? '0 : w_mem_q;

  axi_mem_responder_ram #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_ram (
    .i_clk   (s_axi_clk),
    .i_rst_n (s_aresetn),
    .i_we    (w_mem_we),
    .i_waddr (r_widx),
    .i_wdata (s_axi_WDATA),
    .i_wstrb (s_axi_WSTRB),
    .i_re    (w_mem_re),
    .i_raddr (r_ridx),
    .o_rdata (w_mem_q)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed plus randomized bench for axi_mem_responder against a word-array reference model.
module tb_axi_mem_responder;

  logic        clk = 1'b0;
  logic        s_aresetn = 1'b1;
  logic [3:0]  s_axi_AWID = '0, s_axi_ARID = '0, s_axi_BID, s_axi_RID;
  logic [31:0] s_axi_AWADDR = '0, s_axi_ARADDR = '0, s_axi_WDATA = '0, s_axi_RDATA;
  logic [7:0]  s_axi_AWLEN = '0, s_axi_ARLEN = '0;
  logic [1:0]  s_axi_AWBURST = '0, s_axi_ARBURST = '0, s_axi_BRESP, s_axi_RRESP;
  logic [3:0]  s_axi_WSTRB = '0;
  logic        s_axi_AWVALID = 1'b0, s_axi_WLAST = 1'b0, s_axi_WVALID = 1'b0;
  logic        s_axi_BREADY = 1'b0, s_axi_ARVALID = 1'b0, s_axi_RREADY = 1'b0;
  logic        s_axi_AWREADY, s_axi_WREADY, s_axi_BVALID, s_axi_ARREADY, s_axi_RLAST, s_axi_RVALID;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] wq [300];
  logic [3:0]  sq [300];

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .s_axi_clk(clk), .s_aresetn(s_aresetn),
    .s_axi_AWID(s_axi_AWID), .s_axi_AWADDR(s_axi_AWADDR), .s_axi_AWLEN(s_axi_AWLEN),
    .s_axi_AWBURST(s_axi_AWBURST), .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY),
    .s_axi_WDATA(s_axi_WDATA), .s_axi_WSTRB(s_axi_WSTRB), .s_axi_WLAST(s_axi_WLAST),
    .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY),
    .s_axi_BID(s_axi_BID), .s_axi_BRESP(s_axi_BRESP), .s_axi_BVALID(s_axi_BVALID), .s_axi_BREADY(s_axi_BREADY),
    .s_axi_ARID(s_axi_ARID), .s_axi_ARADDR(s_axi_ARADDR), .s_axi_ARLEN(s_axi_ARLEN),
    .s_axi_ARBURST(s_axi_ARBURST), .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARREADY(s_axi_ARREADY),
    .s_axi_RID(s_axi_RID), .s_axi_RDATA(s_axi_RDATA), .s_axi_RRESP(s_axi_RRESP),
    .s_axi_RLAST(s_axi_RLAST), .s_axi_RVALID(s_axi_RVALID), .s_axi_RREADY(s_axi_RREADY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic oor(input logic [31:0] a);
`ifdef AXI_RESP_DECERR_EN
    return a[31:10] != 22'd0;
`else
    return 1'b0;
`endif
  endfunction

  // Word index of beat n: FIXED stays put, INCR/WRAP step by one word, modulo the 256-word memory.
  function automatic int widx(input logic [31:0] a, input logic [1:0] burst, input int n);
    return (int'(a[31:2]) + ((burst == 2'b00) ? 0 : n)) % 256;
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input int bdelay);
    int n, k;
    logic [1:0] exp_resp;
    s_axi_AWID = id; s_axi_AWADDR = addr; s_axi_AWLEN = len; s_axi_AWBURST = burst; s_axi_AWVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_AWREADY && n < 50) begin @(negedge clk); n++; end
    check("aw_handshake", s_axi_AWREADY, 1'b1);
    @(posedge clk); #1 s_axi_AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_axi_WDATA = wq[i]; s_axi_WSTRB = sq[i]; s_axi_WLAST = (i == nbeats - 1); s_axi_WVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_axi_WREADY && n < 50) begin @(negedge clk); n++; end
      check("w_handshake", s_axi_WREADY, 1'b1);
      @(posedge clk); #1;
    end
    s_axi_WVALID = 1'b0; s_axi_WLAST = 1'b0;
    for (int i = 0; i < nbeats && i <= int'(len); i++) begin
      if (!oor(addr)) begin
        k = widx(addr, burst, i);
        for (int b = 0; b < 4; b++) if (sq[i][b]) ref_mem[k][b*8 +: 8] = wq[i][b*8 +: 8];
      end
    end
    exp_resp = oor(addr) ? 2'b11 : ((nbeats == int'(len) + 1) ? 2'b00 : 2'b10);
    @(negedge clk);
    check("b_valid_next_cycle", s_axi_BVALID, 1'b1);
    for (int d = 0; d < bdelay; d++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("b_stall_hold", {s_axi_BVALID, s_axi_AWREADY, s_axi_BID, s_axi_BRESP}, {1'b1, 1'b0, id, exp_resp});
    end
    @(posedge clk); #1 s_axi_BREADY = 1'b1;
    @(negedge clk);
    check("b_resp", {s_axi_BVALID, s_axi_BID, s_axi_BRESP}, {1'b1, id, exp_resp});
    @(posedge clk); #1 s_axi_BREADY = 1'b0;
    @(negedge clk);
    check("b_done_idle", {s_axi_BVALID, s_axi_AWREADY}, 2'b01);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [63:0] rr_pat);
    int n, cyc, beat, first;
    logic stalled;
    logic [38:0] held, exp_t;
    s_axi_ARID = id; s_axi_ARADDR = addr; s_axi_ARLEN = len; s_axi_ARBURST = burst; s_axi_ARVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_ARREADY && n < 50) begin @(negedge clk); n++; end
    check("ar_handshake", s_axi_ARREADY, 1'b1);
    @(posedge clk); #1 s_axi_ARVALID = 1'b0; s_axi_RREADY = rr_pat[1];
    cyc = 0; beat = 0; first = 0; stalled = 1'b0; held = '0;
    while (beat <= int'(len) && cyc < 600) begin
      @(negedge clk); cyc++;
      if (stalled)
        check("r_stall_stable", {s_axi_RVALID, s_axi_RDATA, s_axi_RID, s_axi_RRESP, s_axi_RLAST}, {1'b1, held});
      if (s_axi_RVALID) begin
        if (first == 0) begin first = cyc; check("r_first_latency", first, 2); end
        if (s_axi_RREADY) begin
          exp_t = {oor(addr) ? 32'd0 : ref_mem[widx(addr, burst, beat)], id,
                   oor(addr) ? 2'b11 : 2'b00, beat == int'(len)};
          check("r_beat", {s_axi_RDATA, s_axi_RID, s_axi_RRESP, s_axi_RLAST}, exp_t);
          beat++; stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {s_axi_RDATA, s_axi_RID, s_axi_RRESP, s_axi_RLAST};
        end
      end
      @(posedge clk); #1 s_axi_RREADY = (cyc + 1 < 64) ? rr_pat[cyc+1] : 1'b1;
    end
    check("r_beat_count", beat, int'(len) + 1);
    s_axi_RREADY = 1'b0;
    @(negedge clk);
    check("r_back_idle", {s_axi_RVALID, s_axi_ARREADY}, 2'b01);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  bu;
    int          nb, r;

    #3 s_aresetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {s_axi_AWREADY, s_axi_WREADY, s_axi_ARREADY, s_axi_BVALID, s_axi_RVALID,
                            s_axi_BID, s_axi_BRESP, s_axi_RID, s_axi_RDATA, s_axi_RRESP, s_axi_RLAST}, 64'd0);
    s_aresetn = 1'b1;
    #1 check("ready_before_first_clk", {s_axi_AWREADY, s_axi_ARREADY}, 2'b00);
    @(posedge clk); #1 check("ready_first_clk", {s_axi_AWREADY, s_axi_ARREADY}, 2'b11);

    // Fill every word with one max-length burst so all later reads are defined.
    for (int i = 0; i < 256; i++) begin wq[i] = $urandom; sq[i] = 4'hF; end
    do_write(4'd7, 32'h0, 8'd255, 2'b01, 256, 0);

    for (int i = 0; i < 4; i++) begin wq[i] = 32'hA0 + i; sq[i] = 4'hF; end
    do_write(4'd5, 32'h10, 8'd3, 2'b01, 4, 0);
    do_read(4'd2, 32'h10, 8'd3, 2'b01, '1);

    wq[0] = 32'h11; wq[1] = 32'h22; sq[0] = 4'hF; sq[1] = 4'hF;
    do_write(4'd1, 32'h20, 8'd1, 2'b00, 2, 0);
    do_read(4'd3, 32'h20, 8'd0, 2'b01, '1);

    do_read(4'd4, 32'h10, 8'd7, 2'b01, 64'hFFFF_FFFF_FFFF_FFCF);
    wq[0] = 32'hDEAD_BEEF; sq[0] = 4'hF;
    do_write(4'd6, 32'h30, 8'd0, 2'b01, 1, 5);

    for (int i = 0; i < 4; i++) begin wq[i] = 32'hC0 + i; sq[i] = 4'hF; end
    do_write(4'd8, 32'h60, 8'd3, 2'b01, 2, 0);
    do_write(4'd9, 32'h80, 8'd1, 2'b01, 4, 0);
    do_read(4'd9, 32'h60, 8'd3, 2'b01, '1);
    do_read(4'd10, 32'h80, 8'd3, 2'b01, '1);

    for (int i = 0; i < 4; i++) begin wq[i] = 32'hE0 + i; sq[i] = 4'b0101 << (i % 2); end
    do_write(4'd11, 32'h3F8, 8'd3, 2'b01, 4, 1);
    do_write(4'd12, 32'h3FC, 8'd1, 2'b10, 2, 0);
    do_read(4'd13, 32'h3F8, 8'd3, 2'b10, '1);

    do_read(4'd14, 32'h1000_0000, 8'd2, 2'b00, '1);
    wq[0] = 32'h5A5A_0044; sq[0] = 4'hF;
    do_write(4'd15, 32'h1000_0044, 8'd0, 2'b01, 1, 0);
    do_read(4'd0, 32'h44, 8'd0, 2'b01, '1);

    for (int t = 0; t < 12; t++) begin
      a  = {($urandom_range(0, 3) == 0) ? 22'($urandom) : 22'd0, 8'($urandom), 2'b00};
      l  = 8'($urandom_range(0, 15));
      bu = 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 5);
      nb = (r == 0) ? ((l == 0) ? 2 : int'(l)) : (r == 1) ? int'(l) + 2 : int'(l) + 1;
      for (int i = 0; i < nb; i++) begin wq[i] = $urandom; sq[i] = 4'($urandom); end
      do_write(4'($urandom), a, l, bu, nb, $urandom_range(0, 3));
      do_read(4'($urandom), a, l, bu, {$urandom, $urandom});
    end

    s_axi_ARID = 4'd1; s_axi_ARADDR = 32'h40; s_axi_ARLEN = 8'd15; s_axi_ARBURST = 2'b01;
    s_axi_ARVALID = 1'b1; s_axi_RREADY = 1'b1;
    r = 0;
    @(negedge clk);
    while (!s_axi_ARREADY && r < 50) begin @(negedge clk); r++; end
    check("rst_ar_handshake", s_axi_ARREADY, 1'b1);
    @(posedge clk); #1 s_axi_ARVALID = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_mid_burst_rvalid", s_axi_RVALID, 1'b1);
    #2 s_aresetn = 1'b0;
    #1 check("rst_async_clear", {s_axi_RVALID, s_axi_ARREADY, s_axi_AWREADY, s_axi_WREADY, s_axi_BVALID,
                                 s_axi_RLAST, s_axi_RDATA, s_axi_RID, s_axi_RRESP}, 64'd0);
    s_axi_RREADY = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_aresetn = 1'b1;
    #1 check("rst_release_before_clk", {s_axi_ARREADY, s_axi_AWREADY}, 2'b00);
    @(posedge clk);
    #1 check("rst_ready_first_clk", {s_axi_ARREADY, s_axi_AWREADY, s_axi_RVALID}, 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter ID_W, default 4, giving the AXI ID width.
REQ-002 SHALL have parameter DATA_W, default 32, giving the data width; bytes per beat = DATA_W/8.
REQ-003 SHALL have parameter MEM_AW, default 8, giving log2 of memory depth in words (256 x 32 bits).
REQ-004 SHALL have port s_axi_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port s_aresetn, input, width 1: reset, asynchronous and active-low.
REQ-006 SHALL have AW channel ports: s_axi_AWID in ID_W, s_axi_AWADDR in 32, s_axi_AWLEN in 8, s_axi_AWBURST in 2, s_axi_AWVALID in 1, s_axi_AWREADY out 1.
REQ-007 SHALL have W channel ports: s_axi_WDATA in DATA_W, s_axi_WSTRB in DATA_W/8, s_axi_WLAST in 1, s_axi_WVALID in 1, s_axi_WREADY out 1.
REQ-008 SHALL have B channel ports: s_axi_BID out ID_W, s_axi_BRESP out 2, s_axi_BVALID out 1, s_axi_BREADY in 1.
REQ-009 SHALL have AR channel ports: s_axi_ARID in ID_W, s_axi_ARADDR in 32, s_axi_ARLEN in 8, s_axi_ARBURST in 2, s_axi_ARVALID in 1, s_axi_ARREADY out 1.
REQ-010 SHALL have R channel ports: s_axi_RID out ID_W, s_axi_RDATA out DATA_W, s_axi_RRESP out 2, s_axi_RLAST out 1, s_axi_RVALID out 1, s_axi_RREADY in 1.

Function
REQ-011 SHALL implement an AXI slave backed by internal memory: beats = LEN+1, word index = ADDR[MEM_AW+1:2], transfer size fixed at DATA_W.
REQ-012 SHALL hold the index constant on every beat for burst FIXED (2'b00), and add 1 per beat for INCR (2'b01); WRAP (2'b10) SHALL behave as INCR; the index SHALL wrap modulo 2^MEM_AW.
REQ-013 SHALL run the write FSM W_IDLE -> W_DATA on AW handshake (AWREADY=1 only in W_IDLE), W_DATA -> W_RESP on the WLAST handshake (WREADY=1 only in W_DATA), and W_RESP -> W_IDLE on BVALID&BREADY.
REQ-014 SHALL write each W beat with WSTRB byte enables in the handshake cycle; beats beyond LEN+1 SHALL be dropped, not written.
REQ-015 SHALL assert BVALID in the cycle after the WLAST handshake, with BID = captured AWID, and hold BVALID/BID/BRESP stable until BREADY.
REQ-016 SHALL set BRESP=OKAY (2'b00) when the counted beats equal LEN+1, else SLVERR (2'b10).
REQ-017 SHALL run the read FSM R_IDLE -> R_DATA on AR handshake (ARREADY=1 only in R_IDLE), and R_DATA -> R_IDLE on the handshake of the beat with RLAST=1.
REQ-018 SHALL assert the first RVALID exactly 2 cycles after the AR handshake, and sustain 1 beat/cycle while RREADY=1.
REQ-019 SHALL hold RDATA/RID/RRESP/RLAST stable while RVALID&!RREADY; RLAST=1 only on beat LEN+1; RID = captured ARID.
REQ-020 SHALL run the read and write FSMs concurrently; a same-cycle read and write to one index SHALL return the old data.
REQ-021 SHALL keep one outstanding transaction per direction; a new AW/AR SHALL stall until its FSM returns to idle.

Reset
REQ-022 SHALL, while s_aresetn=0, force both FSMs to idle, all VALID outputs to 0, AWREADY/ARREADY to 0, WREADY to 0, and BID/BRESP/RID/RDATA/RRESP/RLAST to 0; memory contents are undefined.
REQ-023 SHALL abandon any in-flight burst on reset assertion, and assert AWREADY/ARREADY on the first clock after deassertion.

Configuration
REQ-024 SHALL, with macro AXI_RESP_DECERR_EN defined, treat an address with ADDR[31:MEM_AW+2] != 0 as out of range: writes are dropped with BRESP=DECERR (2'b11), and reads return data 0 with RRESP=2'b11 on every beat, burst length unchanged.
REQ-025 SHALL, without AXI_RESP_DECERR_EN, ignore the upper address bits (aliasing), so out-of-range responses are never generated.

Structure
REQ-026 SHALL place burst encodings, RESP encodings and the FSM state enums in a shared package axi_resp_pkg.
REQ-027 SHALL implement storage as one sub-module, axi_mem_responder_ram: a simple dual-port RAM with a byte-enabled write port and a 1-cycle registered read port.

Verification
REQ-028 Bench SHALL cover: AW(ID=5, ADDR=0x10, LEN=3, INCR), 4 beats 0xA0..0xA3 -> B(ID=5, OKAY); then AR(ID=2, ADDR=0x10, LEN=3) -> R beats 0xA0..0xA3, RLAST on beat 4, RID=2.
REQ-029 Bench SHALL cover: FIXED write with LEN=1 and data 0x11 then 0x22 to 0x20 -> reading 0x20 returns 0x22.
REQ-030 Bench SHALL cover: RREADY toggled 1-0-0-1 mid-burst -> no beat lost or duplicated, RDATA stable while stalled; BREADY held 0 for 5 cycles -> BVALID stays 1 and AWREADY stays 0.
REQ-031 Bench SHALL cover: AWLEN=3 with WLAST on beat 2 -> BRESP=SLVERR; AWLEN=1 with WLAST on beat 4 -> beats 3 and 4 are not written.
REQ-032 Bench SHALL cover: with AXI_RESP_DECERR_EN, AR at 0x1000_0000 with LEN=2 -> 3 beats of data 0 with RRESP=2'b11; without the macro, the same AR returns the contents of word 0.
REQ-033 Bench SHALL cover: s_aresetn asserted mid read burst -> RVALID=0 immediately and ARREADY=1 on the first clock after release.
